mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between two requesters: A = CPU pipeline, B = debug/loader unit.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
//
// Handshake: a requester raises i_req_x together with i_we_x/i_addr_x/i_wdata_x
// and holds all of them stable until it sees its one-cycle o_ack_x pulse. The
// ack marks completion; for reads o_rdata is valid only in that ack cycle. A
// request still high in the cycle after its ack is taken as a new request.
// The memory side gets one o_mem_en pulse per access and returns i_mem_rdata
// a fixed MEM_LAT cycles later.
interface mem_port_arbiter_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_DATA = 32
);
  logic               i_req_a;
  logic               i_we_a;
  logic [NB_ADDR-1:0] i_addr_a;
  logic [NB_DATA-1:0] i_wdata_a;
  logic               i_req_b;
  logic               i_we_b;
  logic [NB_ADDR-1:0] i_addr_b;
  logic [NB_DATA-1:0] i_wdata_b;
  logic               i_lock_b;
  logic [NB_DATA-1:0] i_mem_rdata;
  logic               o_mem_en;
  logic               o_mem_we;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic               o_sel;
  logic               o_ack_a;
  logic               o_ack_b;
  logic [NB_DATA-1:0] o_rdata;
  logic               o_busy;

  // Requesters and memory model side
  modport master (
    output i_req_a, i_we_a, i_addr_a, i_wdata_a,
    output i_req_b, i_we_b, i_addr_b, i_wdata_b,
    output i_lock_b, i_mem_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_sel, o_ack_a, o_ack_b, o_rdata, o_busy
  );

  // Arbiter side
  modport slave (
    input  i_req_a, i_we_a, i_addr_a, i_wdata_a,
    input  i_req_b, i_we_b, i_addr_b, i_wdata_b,
    input  i_lock_b, i_mem_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_sel, o_ack_a, o_ack_b, o_rdata, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory. Requester A is the CPU
// pipeline, B is the debug/loader unit. Each access walks IDLE -> ISSUE ->
// (WAIT) -> RESP; the registered select drives a 2:1 mux that puts the
// winner's we/addr/wdata on the memory port.

// Plain 2:1 steering mux; sel=0 picks a, sel=1 picks b.
module mux_2to1 #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mem_port_arbiter #(
  parameter int NB_ADDR       = 32,
  parameter int NB_DATA       = 32,
  parameter int MEM_LAT       = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WAIT counter only has to hold MEM_LAT-2
  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;
  localparam int MUX_W = NB_ADDR + NB_DATA + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sel_q;
  logic             last_grant;   // 0 = A, 1 = B
  logic             mem_en_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic             busy_q;

  logic             elig_a;
  logic             elig_b;
  logic             pick_b;
  logic [MUX_W-1:0] mux_y;

  // Winner selection for the current IDLE cycle; lock_b masks A entirely
  always_comb begin
    elig_a = bus.i_req_a & ~bus.i_lock_b;
    elig_b = bus.i_req_b;
    pick_b = 1'b0;
    if (elig_a && elig_b) begin
      if (PRIORITY_MODE == 0) pick_b = ~last_grant;
      else                    pick_b = 1'b0;
    end else begin
      pick_b = elig_b;
    end
  end

  // Access sequencer with registered strobes, acks, select and busy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= 1'b0;
      last_grant <= 1'b1;
      mem_en_q   <= 1'b0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_a || elig_b) begin
            sel_q      <= pick_b;
            last_grant <= pick_b;
            mem_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_LAT == 1) begin
            ack_a_q <= ~sel_q;
            ack_b_q <= sel_q;
            state   <= RESP;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            ack_a_q <= ~sel_q;
            ack_b_q <= sel_q;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Requester fields are held until ack, so the mux output is stable for the whole access
  mux_2to1 #(.W(MUX_W)) u_mux (
    .sel (sel_q),
    .a   ({bus.i_we_a, bus.i_addr_a, bus.i_wdata_a}),
    .b   ({bus.i_we_b, bus.i_addr_b, bus.i_wdata_b}),
    .y   (mux_y)
  );

  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_en_q & mux_y[MUX_W-1];
  assign bus.o_mem_addr  = mux_y[NB_DATA +: NB_ADDR];
  assign bus.o_mem_wdata = mux_y[NB_DATA-1:0];
  assign bus.o_sel       = sel_q;
  assign bus.o_ack_a     = ack_a_q;
  assign bus.o_ack_b     = ack_b_q;
  assign bus.o_rdata     = bus.i_mem_rdata;
  assign bus.o_busy      = busy_q;
  assign o_state         = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one round-robin instance and one
// fixed-priority instance share clock/reset; each has its own memory model
// and expected-completion queue.
module tb_mem_port_arbiter;
  localparam int NB_ADDR = 32;
  localparam int NB_DATA = 32;
  localparam int MEM_LAT = 2;
  localparam int EW      = NB_DATA + 2;   // {is_write, who(1=B), rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus_rr ();
  mem_port_arbiter_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus_fp ();
  logic [1:0] state_rr;
  logic [1:0] state_fp;

  mem_port_arbiter #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .MEM_LAT(MEM_LAT), .PRIORITY_MODE(0)) dut_rr (
    .i_clk(clk), .i_rst(rst), .bus(bus_rr), .o_state(state_rr)
  );
  mem_port_arbiter #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .MEM_LAT(MEM_LAT), .PRIORITY_MODE(1)) dut_fp (
    .i_clk(clk), .i_rst(rst), .bus(bus_fp), .o_state(state_fp)
  );

  // ---------------- memory model ----------------
  logic [NB_DATA-1:0] mem_arr [logic [NB_ADDR-1:0]];

  function automatic logic [NB_DATA-1:0] mem_rd(input logic [NB_ADDR-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  logic [NB_DATA-1:0] rr_p0 = '0, rr_p1 = '0, fp_p0 = '0, fp_p1 = '0;
  assign bus_rr.i_mem_rdata = rr_p1;
  assign bus_fp.i_mem_rdata = fp_p1;

  always @(posedge clk) begin
    if (bus_rr.o_mem_en && bus_rr.o_mem_we) mem_arr[bus_rr.o_mem_addr] = bus_rr.o_mem_wdata;
    if (bus_rr.o_mem_en && !bus_rr.o_mem_we) rr_p0 <= mem_rd(bus_rr.o_mem_addr);
    rr_p1 <= rr_p0;
    if (bus_fp.o_mem_en && !bus_fp.o_mem_we) fp_p0 <= mem_rd(bus_fp.o_mem_addr);
    fp_p1 <= fp_p0;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_rr_q[$];
  logic [EW-1:0] exp_fp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [EW-1:0] mk(input logic wr, input logic who_b, input logic [NB_DATA-1:0] d);
    return {wr, who_b, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, retire any completed access
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    if (bus_rr.o_ack_a || bus_rr.o_ack_b) begin
      if (exp_rr_q.size() == 0) begin
        chk("rr_unexpected_ack", 64'({bus_rr.o_ack_a, bus_rr.o_ack_b}), 64'(0));
      end else begin
        e = exp_rr_q.pop_front();
        chk("rr_ack_who", 64'({bus_rr.o_ack_a, bus_rr.o_ack_b}), e[NB_DATA] ? 64'(2'b01) : 64'(2'b10));
        if (!e[NB_DATA+1]) chk("rr_rdata", 64'(bus_rr.o_rdata), 64'(e[NB_DATA-1:0]));
      end
    end
    if (bus_fp.o_ack_a || bus_fp.o_ack_b) begin
      if (exp_fp_q.size() == 0) begin
        chk("fp_unexpected_ack", 64'({bus_fp.o_ack_a, bus_fp.o_ack_b}), 64'(0));
      end else begin
        e = exp_fp_q.pop_front();
        chk("fp_ack_who", 64'({bus_fp.o_ack_a, bus_fp.o_ack_b}), e[NB_DATA] ? 64'(2'b01) : 64'(2'b10));
        if (!e[NB_DATA+1]) chk("fp_rdata", 64'(bus_fp.o_rdata), 64'(e[NB_DATA-1:0]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus_rr.i_req_a = 0; bus_rr.i_we_a = 0; bus_rr.i_addr_a = '0; bus_rr.i_wdata_a = '0;
    bus_rr.i_req_b = 0; bus_rr.i_we_b = 0; bus_rr.i_addr_b = '0; bus_rr.i_wdata_b = '0;
    bus_rr.i_lock_b = 0;
    bus_fp.i_req_a = 0; bus_fp.i_we_a = 0; bus_fp.i_addr_a = '0; bus_fp.i_wdata_a = '0;
    bus_fp.i_req_b = 0; bus_fp.i_we_b = 0; bus_fp.i_addr_b = '0; bus_fp.i_wdata_b = '0;
    bus_fp.i_lock_b = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    apply_reset();

    // Reset state
    chk("rst_state", 64'(state_rr), 64'(0));
    chk("rst_sel", 64'(bus_rr.o_sel), 64'(0));
    chk("rst_busy", 64'(bus_rr.o_busy), 64'(0));
    chk("rst_mem_en", 64'(bus_rr.o_mem_en), 64'(0));
    chk("rst_acks", 64'({bus_rr.o_ack_a, bus_rr.o_ack_b}), 64'(0));
    chk("rst_fp_busy", 64'(bus_fp.o_busy), 64'(0));

    // 1: single A read of 0x10
    bus_rr.i_req_a = 1; bus_rr.i_addr_a = 32'h10;
    exp_rr_q.push_back(mk(1'b0, 1'b0, mem_rd(32'h10)));
    tick();
    chk("t1_en_issue", 64'(bus_rr.o_mem_en), 64'(1));
    chk("t1_sel", 64'(bus_rr.o_sel), 64'(0));
    chk("t1_addr", 64'(bus_rr.o_mem_addr), 64'(32'h10));
    chk("t1_busy1", 64'(bus_rr.o_busy), 64'(1));
    tick();
    chk("t1_en_wait", 64'(bus_rr.o_mem_en), 64'(0));
    chk("t1_ack_early", 64'(bus_rr.o_ack_a), 64'(0));
    tick();
    chk("t1_ack_a", 64'(bus_rr.o_ack_a), 64'(1));
    chk("t1_busy3", 64'(bus_rr.o_busy), 64'(1));
    bus_rr.i_req_a = 0;
    tick();
    chk("t1_idle_busy", 64'(bus_rr.o_busy), 64'(0));
    chk("t1_ack_once", 64'(bus_rr.o_ack_a), 64'(0));

    // 2: both requesting right after reset, round-robin alternation
    apply_reset();
    bus_rr.i_req_a = 1; bus_rr.i_addr_a = 32'h10;
    bus_rr.i_req_b = 1; bus_rr.i_addr_b = 32'h20;
    for (int k = 0; k < 2; k++) begin
      exp_rr_q.push_back(mk(1'b0, 1'b0, mem_rd(32'h10)));
      exp_rr_q.push_back(mk(1'b0, 1'b1, mem_rd(32'h20)));
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t2_en", 64'(bus_rr.o_mem_en), 64'((i % 4) == 1));
      if ((i % 4) == 1) chk("t2_sel", 64'(bus_rr.o_sel), 64'((i / 4) % 2));
      chk("t2_ack_a", 64'(bus_rr.o_ack_a), 64'(((i % 4) == 3) && (((i / 4) % 2) == 0)));
      chk("t2_ack_b", 64'(bus_rr.o_ack_b), 64'(((i % 4) == 3) && (((i / 4) % 2) == 1)));
    end
    bus_rr.i_req_a = 0; bus_rr.i_req_b = 0;
    tick();
    chk("t2_idle", 64'(bus_rr.o_busy), 64'(0));

    // 3: fixed priority, both held -> only A, every 4 cycles
    bus_fp.i_req_a = 1; bus_fp.i_addr_a = 32'h40;
    bus_fp.i_req_b = 1; bus_fp.i_addr_b = 32'h44;
    for (int k = 0; k < 3; k++) exp_fp_q.push_back(mk(1'b0, 1'b0, mem_rd(32'h40)));
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("t3_ack_b", 64'(bus_fp.o_ack_b), 64'(0));
      chk("t3_ack_a", 64'(bus_fp.o_ack_a), 64'((i % 4) == 3));
    end
    bus_fp.i_req_a = 0; bus_fp.i_req_b = 0;

    // 4: lock_b -> only B; dropping lock lets A in next
    bus_rr.i_lock_b = 1;
    bus_rr.i_req_a = 1; bus_rr.i_addr_a = 32'h50;
    bus_rr.i_req_b = 1; bus_rr.i_addr_b = 32'h54;
    exp_rr_q.push_back(mk(1'b0, 1'b1, mem_rd(32'h54)));
    exp_rr_q.push_back(mk(1'b0, 1'b1, mem_rd(32'h54)));
    exp_rr_q.push_back(mk(1'b0, 1'b0, mem_rd(32'h50)));
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("t4_ack_a", 64'(bus_rr.o_ack_a), 64'(i == 11));
      chk("t4_ack_b", 64'(bus_rr.o_ack_b), 64'((i == 3) || (i == 7)));
      if ((i == 1) || (i == 5)) chk("t4_sel_b", 64'(bus_rr.o_sel), 64'(1));
      if (i == 9) chk("t4_sel_a", 64'(bus_rr.o_sel), 64'(0));
      if (i == 8) bus_rr.i_lock_b = 0;
    end
    bus_rr.i_req_a = 0; bus_rr.i_req_b = 0;
    tick();

    // 5: reset during WAIT abandons the access; a fresh request runs normally
    bus_rr.i_req_a = 1; bus_rr.i_addr_a = 32'h60;
    tick();
    chk("t5_en", 64'(bus_rr.o_mem_en), 64'(1));
    tick();
    chk("t5_in_wait", 64'(state_rr), 64'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_outs", 64'({bus_rr.o_ack_a, bus_rr.o_ack_b, bus_rr.o_mem_en, bus_rr.o_busy, bus_rr.o_sel}), 64'(0));
    chk("t5_rst_state", 64'(state_rr), 64'(0));
    exp_rr_q.push_back(mk(1'b0, 1'b0, mem_rd(32'h60)));
    tick();
    chk("t5_reissue", 64'(bus_rr.o_mem_en), 64'(1));
    tick();
    chk("t5_no_ack", 64'(bus_rr.o_ack_a), 64'(0));
    tick();
    chk("t5_ack_a", 64'(bus_rr.o_ack_a), 64'(1));
    bus_rr.i_req_a = 0;
    tick();

    // 6: B write of 0xDEADBEEF to 0x4, then read it back
    bus_rr.i_req_b = 1; bus_rr.i_we_b = 1; bus_rr.i_addr_b = 32'h4; bus_rr.i_wdata_b = 32'hDEADBEEF;
    exp_rr_q.push_back(mk(1'b1, 1'b1, '0));
    tick();
    chk("t6_en", 64'(bus_rr.o_mem_en), 64'(1));
    chk("t6_we", 64'(bus_rr.o_mem_we), 64'(1));
    chk("t6_addr", 64'(bus_rr.o_mem_addr), 64'(32'h4));
    chk("t6_wdata", 64'(bus_rr.o_mem_wdata), 64'(32'hDEADBEEF));
    tick();
    chk("t6_we_off", 64'(bus_rr.o_mem_we), 64'(0));
    tick();
    chk("t6_ack_b", 64'(bus_rr.o_ack_b), 64'(1));
    bus_rr.i_req_b = 0; bus_rr.i_we_b = 0;
    tick();
    bus_rr.i_req_b = 1;
    exp_rr_q.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
    tick();
    chk("t6_rd_we", 64'(bus_rr.o_mem_we), 64'(0));
    tick();
    tick();
    chk("t6_rd_ack_b", 64'(bus_rr.o_ack_b), 64'(1));
    bus_rr.i_req_b = 0;
    tick();
    tick();

    // ---------------- final report ----------------
    chk("rr_queue_drained", 64'(exp_rr_q.size()), 64'(0));
    chk("fp_queue_drained", 64'(exp_fp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
